// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the register-file write-back arbiter.
// Optional starvation guard is enabled with macro WB_ARB_STARVE_GUARD_EN.
package wb_arb_pkg;

    localparam int DEPTH_DEF        = 2;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int REG_W            = 5;
    localparam int DATA_W           = 32;

    // "reg" is a keyword, so the destination field is reg_idx.
    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  reg_idx;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_aux_fifo.sv
// Circular buffer of pending aux results with per-entry invalidate-by-register.
// Invalidated entries keep their slot until they reach the head and are popped.
module wb_aux_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    input  logic             inv_en,
    input  logic [REG_W-1:0] inv_reg,
    output logic             full,
    output logic             empty,
    output wb_entry_t        head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (inv_en && mem_q[i].reg_idx == inv_reg) mem_d[i].valid = 1'b0;
        end
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state updates use <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset because stale valid bits would be written out.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Arbitrates the single register-file write port between the MEM/WB pipeline and a
// buffered mult/div result stream. Macro WB_ARB_STARVE_GUARD_EN adds a starvation stall.
module wb_write_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipeRegWrite,
    input  logic [REG_W-1:0]  pipeWriteReg,
    input  logic [DATA_W-1:0] pipeWriteData,
    input  logic              auxValid,
    input  logic [REG_W-1:0]  auxWriteReg,
    input  logic [DATA_W-1:0] auxWriteData,
    output logic              auxReady,
    output logic              rfWriteEnable,
    output logic [REG_W-1:0]  rfWriteReg,
    output logic [DATA_W-1:0] rfWriteData,
    output logic              stallPipe
);

    wb_entry_t         head, push_entry;
    logic              full, empty;
    logic              stall_now, pipe_grant, head_valid, head_grant;
    logic              push, pop, aux_drop;
    logic              rf_we_q, rf_we_d;
    logic [REG_W-1:0]  rf_reg_q, rf_reg_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    logic            stall_q, stall_d;
    logic [SC_W-1:0] starve_q, starve_d;

    assign stall_now = stall_q;

    always_comb begin
        stall_d  = 1'b0;
        starve_d = '0;
        if (head_valid && pipe_grant) begin
            if (starve_q == SC_W'(STARVE_LIMIT - 1)) stall_d  = 1'b1;
            else                                     starve_d = starve_q + 1'b1;
        end
    end
`else
    assign stall_now = 1'b0;
`endif

    assign stallPipe  = stall_now;
    assign auxReady   = !full;
    assign pipe_grant = !stall_now && pipeRegWrite && (pipeWriteReg != '0);
    assign head_valid = !empty && head.valid;
    assign head_grant = head_valid && !pipe_grant;
    // An invalidated head drains even while the pipeline owns the write port.
    assign pop        = !empty && (!head.valid || !pipe_grant);
    assign aux_drop   = (auxWriteReg == '0) || (pipe_grant && auxWriteReg == pipeWriteReg);
    assign push       = auxValid && auxReady && !aux_drop;
    assign push_entry = '{valid: 1'b1, reg_idx: auxWriteReg, data: auxWriteData};

    always_comb begin
        rf_we_d   = 1'b0;
        rf_reg_d  = '0;
        rf_data_d = '0;
        if (pipe_grant) begin
            rf_we_d   = 1'b1;
            rf_reg_d  = pipeWriteReg;
            rf_data_d = pipeWriteData;
        end else if (head_grant) begin
            rf_we_d   = 1'b1;
            rf_reg_d  = head.reg_idx;
            rf_data_d = head.data;
        end
    end

    wb_aux_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .inv_en     (pipe_grant),
        .inv_reg    (pipeWriteReg),
        .full       (full),
        .empty      (empty),
        .head       (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q   <= 1'b0;
            rf_reg_q  <= '0;
            rf_data_q <= '0;
`ifdef WB_ARB_STARVE_GUARD_EN
            stall_q   <= 1'b0;
            starve_q  <= '0;
`endif
        end else begin
            rf_we_q   <= rf_we_d;
            rf_reg_q  <= rf_reg_d;
            rf_data_q <= rf_data_d;
`ifdef WB_ARB_STARVE_GUARD_EN
            stall_q   <= stall_d;
            starve_q  <= starve_d;
`endif
        end
    end

    assign rfWriteEnable = rf_we_q;
    assign rfWriteReg    = rf_reg_q;
    assign rfWriteData   = rf_data_q;

endmodule

// File: doc/wb_write_arbiter.md
WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

Interface
REQ-001 The block SHALL take parameter DEPTH, default 2, as the aux buffer entries (power of two, 2..8).
REQ-002 The block SHALL take parameter STARVE_LIMIT, default 4, as the cycles a buffered aux result may wait before forcing a pipeline stall.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port pipeRegWrite, input, 1: the MEM/WB instruction writes the register file this cycle.
REQ-006 The block SHALL have port pipeWriteReg, input, 5: pipeline destination register.
REQ-007 The block SHALL have port pipeWriteData, input, 32: pipeline write-back data (WB-stage mux output).
REQ-008 The block SHALL have port auxValid, input, 1: the multi-cycle mult/div unit offers a result.
REQ-009 The block SHALL have port auxWriteReg, input, 5: aux destination register.
REQ-010 The block SHALL have port auxWriteData, input, 32: aux result.
REQ-011 The block SHALL have port auxReady, output, 1: buffer can accept an aux result.
REQ-012 The block SHALL have port rfWriteEnable, output, 1: register-file write strobe.
REQ-013 The block SHALL have port rfWriteReg, output, 5: register-file write address.
REQ-014 The block SHALL have port rfWriteData, output, 32: register-file write data.
REQ-015 The block SHALL have port stallPipe, output, 1: freeze request to the pipeline hazard unit.

Function
REQ-016 The rf* outputs SHALL be registered: a grant in cycle N appears on rf* in cycle N+1, one cycle wide.
REQ-017 The aux handshake SHALL be a push when auxValid and auxReady are both 1; auxReady SHALL be 1 exactly when the buffer count is below DEPTH, evaluated before any same-cycle pop (no pass-through when full).
REQ-018 An aux result SHALL never bypass the buffer; it becomes eligible for grant the cycle after it is pushed.
REQ-019 With stallPipe=0 and pipeRegWrite=1 and pipeWriteReg!=0, the pipeline SHALL be granted; otherwise the buffer head, if present, SHALL be granted and popped.
REQ-020 While stallPipe=1, pipeline inputs SHALL be ignored; the frozen instruction is re-presented later.
REQ-021 Writes to register 0, from either source, SHALL be consumed without asserting rfWriteEnable.
REQ-022 On a pipeline grant to register R, every buffered entry with destination R SHALL be invalidated, and a same-cycle aux push with destination R SHALL be dropped, because the pipeline write is younger.
REQ-023 Invalidated entries SHALL free their slot; an invalid head SHALL be popped without a write and SHALL not count as a grant.
REQ-024 The buffer SHALL keep pointers wrapping modulo DEPTH and a count 0..DEPTH; simultaneous push and pop SHALL leave the count unchanged.

Reset
REQ-025 On rst_n=0, the block SHALL asynchronously clear the buffer count, pointers, all valid bits and the starvation counter, and drive rfWriteEnable=0, rfWriteReg=0, rfWriteData=0, stallPipe=0 and auxReady=1 after release.
REQ-026 Reset mid-operation SHALL discard buffered results with no write issued.

Configuration
REQ-027 With macro WB_ARB_STARVE_GUARD_EN defined, a counter SHALL increment each cycle a valid head is not granted; on reaching STARVE_LIMIT it SHALL register stallPipe=1 for exactly one cycle, in which the head is granted, then clear.
REQ-028 Without WB_ARB_STARVE_GUARD_EN, the counter SHALL be absent and stallPipe SHALL be constant 0.

Structure
REQ-029 Package wb_arb_pkg SHALL hold the DEPTH and STARVE_LIMIT defaults, the register-index width constant (5) and the typedef wb_entry_t {valid, reg[4:0], data[31:0]}.
REQ-030 The buffer SHALL be sub-module wb_aux_fifo, with push, pop, full, empty, head and per-entry invalidate-by-register.

Verification
REQ-031 Pipe write $5=0x1234 alone SHALL give rfWriteEnable=1, rfWriteReg=5, rfWriteData=0x1234 the next cycle.
REQ-032 A same-cycle pipe write to $3 and aux push to $7 SHALL write $3 at N+1, then $7 at N+2 once the pipeline is idle.
REQ-033 With continuous pipe writes, two aux pushes SHALL drive auxReady=0 (DEPTH=2); the third offer SHALL be held until space frees.
REQ-034 An aux result for $9 buffered, followed by a pipe write to $9, SHALL produce a single write of the pipeline data and the aux entry SHALL never be written.
REQ-035 Under WB_ARB_STARVE_GUARD_EN, an aux entry starved by continuous pipe writes SHALL raise stallPipe after 4 cycles and be written the following cycle.
REQ-036 An rst_n pulse with 2 entries buffered SHALL give no writes afterward and auxReady=1.
